bfly_cfg_gen: RTL and testbench

// - Iterative, parametrised generator of inverse-butterfly control words for bit extract/deposit (bext/bdep).
// - Takes a raw mask, computes the block popcounts internally and emits all LOG2(XLEN) stage configs.
// - Each stage is produced as thermometer (LROTC of all-ones) segments, one stage per cycle, behind valid/ready handshakes.
// - Sits between operand read and the butterfly network in the bit-manipulation unit.

---
 rtl/bfly_cfg_gen.sv | 165 ++++++++++++++++
 tb/tb_bfly_cfg_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_cfg_gen.sv
// Iterative inverse-butterfly config generator for bext/bdep, one stage per cycle.
// Optional result cache for repeated masks: define BFLY_CFG_CACHE_EN.
module bfly_cfg_gen #(
  parameter int XLEN = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [XLEN-1:0]                   in_mask,
  input  logic                              in_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(XLEN)*(XLEN/2)-1:0]  out_cfg,
  output logic                              out_mode,
  output logic [$clog2(XLEN):0]             out_popcnt,
  output logic                              busy
);

  localparam int LOG2 = $clog2(XLEN);
  localparam int HALF = XLEN / 2;
  localparam int KW   = LOG2 + 1;
  localparam int CW   = $clog2(LOG2) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0]      mask_q;
  logic [CW-1:0]        cnt;
  logic [LOG2*HALF-1:0] stg_all;
  logic [HALF-1:0]      stg_sel;
  logic [KW-1:0]        pc_all;
  logic                 accept;
  logic                 last_stg;
  logic                 hit;

  assign accept   = in_valid & in_ready;
  assign last_stg = (cnt == CW'(LOG2 - 1));
  assign stg_sel  = stg_all[cnt*HALF +: HALF];

  // Every stage is derived from the captured mask; CALC just walks them.
  for (genvar s = 0; s < LOG2; s++) begin : g_stg
    localparam int W = 1 << s;
    for (genvar b = 0; b < HALF / W; b++) begin : g_seg
      logic [KW-1:0] k;
      always_comb begin
        k = '0;
        for (int j = 0; j < W; j++) begin
          k = k + KW'(mask_q[b*2*W + j]);
        end
      end
      for (genvar j = 0; j < W; j++) begin : g_bit
        assign stg_all[s*HALF + b*W + j] = (k <= KW'(j));
      end
    end
  end

  always_comb begin
    pc_all = '0;
    for (int i = 0; i < XLEN; i++) begin
      pc_all = pc_all + KW'(mask_q[i]);
    end
  end

`ifdef BFLY_CFG_CACHE_EN
  logic [XLEN-1:0] last_mask;
  logic            cache_vld;

  assign hit = cache_vld && (in_mask == last_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_mask <= '0;
      cache_vld <= 1'b0;
    end else if (flush) begin
      cache_vld <= 1'b0;
    end else if (state == CALC && last_stg) begin
      last_mask <= mask_q;
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = hit ? DONE : CALC;
          end
        end
        CALC: begin
          if (last_stg) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // A flushed request leaves the data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      cnt        <= '0;
      out_cfg    <= '0;
      out_mode   <= 1'b0;
      out_popcnt <= '0;
    end else if (!flush) begin
      if (accept) begin
        mask_q   <= in_mask;
        out_mode <= in_mode;
        cnt      <= '0;
      end
      if (state == CALC) begin
        out_cfg[cnt*HALF +: HALF] <= stg_sel;
        cnt <= cnt + CW'(1);
        if (last_stg) begin
          out_popcnt <= pc_all;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfly_cfg_gen.sv
// Scoreboard bench for bfly_cfg_gen (XLEN=32).
// Expected configs come from an independent per-bit model.
module tb_bfly_cfg_gen;

  localparam int XLEN = 32;
  localparam int LOG2 = 5;
  localparam int HALF = 16;
  localparam int CFGW = LOG2 * HALF;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_mask;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [CFGW-1:0] out_cfg;
  logic            out_mode;
  logic [LOG2:0]   out_popcnt;
  logic            busy;

  bfly_cfg_gen #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cfg    (out_cfg),
    .out_mode   (out_mode),
    .out_popcnt (out_popcnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [CFGW-1:0] cfg;
    logic [LOG2:0]   pc;
    logic            mode;
    int              lat;
  } exp_t;

  exp_t sb[$];

  bit          tb_cvld = 1'b0;
  logic [31:0] tb_last = '0;

  function automatic logic [CFGW-1:0] model_cfg(input logic [31:0] m);
    logic [CFGW-1:0] r;
    logic [63:0]     seg;
    int              w, b, j, k;
    r = '0;
    for (int s = 0; s < LOG2; s++) begin
      w = 1 << s;
      for (int i = 0; i < HALF; i++) begin
        b   = i / w;
        j   = i % w;
        seg = (64'(m) >> (b * 2 * w)) & ((64'd1 << w) - 64'd1);
        k   = $countones(seg);
        r[s*HALF + i] = (j >= k);
      end
    end
    return r;
  endfunction

  task automatic run_req(input logic [31:0] m, input logic md,
                         input int hold);
    exp_t e;
    exp_t g;
    int   t;
    int   acc;
    int   lat;
    bit   hit;
    @(negedge clk);
    in_mask  = m;
    in_mode  = md;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 128'(t < 50), 128'(1));
    acc = cyc;
    hit = 1'b0;
`ifdef BFLY_CFG_CACHE_EN
    hit = tb_cvld && (m == tb_last);
`endif
    e.cfg  = model_cfg(m);
    e.pc   = (LOG2+1)'($countones(m));
    e.mode = md;
    e.lat  = hit ? 1 : LOG2 + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - acc;
    g = sb.pop_front();
    chk("latency", 128'(lat), 128'(g.lat));
    chk("cfg", 128'(out_cfg), 128'(g.cfg));
    chk("popcnt", 128'(out_popcnt), 128'(g.pc));
    chk("mode", 128'(out_mode), 128'(g.mode));
    tb_cvld = 1'b1;
    tb_last = m;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_cfg", 128'(out_cfg), 128'(g.cfg));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    chk("idle_out_valid", 128'(out_valid), 128'(0));
  endtask

  task automatic flush_calc(input logic [31:0] m);
    int t;
    int seen;
    @(negedge clk);
    in_mask  = m;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tb_cvld = 1'b0;
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_busy", 128'(busy), 128'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 128'(seen), 128'(0));
  endtask

  task automatic flush_accept(input logic [31:0] m);
    @(negedge clk);
    in_mask  = m;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    tb_cvld  = 1'b0;
    chk("flush_acc_busy", 128'(busy), 128'(0));
    chk("flush_acc_in_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic rst_in_done(input logic [31:0] m);
    exp_t e;
    exp_t g;
    int   t;
    @(negedge clk);
    in_mask  = m;
    in_mode  = 1'b1;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    e.cfg  = model_cfg(m);
    e.pc   = (LOG2+1)'($countones(m));
    e.mode = 1'b1;
    e.lat  = 0;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    g = sb.pop_front();
    chk("rst_pre_cfg", 128'(out_cfg), 128'(g.cfg));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_cvld = 1'b0;
    chk("rst_done_valid", 128'(out_valid), 128'(0));
    chk("rst_done_cfg", 128'(out_cfg), 128'(0));
    chk("rst_done_popcnt", 128'(out_popcnt), 128'(0));
    chk("rst_done_mode", 128'(out_mode), 128'(0));
  endtask

  logic [31:0] m_prev;
  logic [31:0] m_cur;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_cfg", 128'(out_cfg), 128'(0));
    chk("rst_popcnt", 128'(out_popcnt), 128'(0));
    chk("rst_mode", 128'(out_mode), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    run_req(32'h0000_0000, 1'b0, 0);
    for (int s = 0; s < LOG2; s++) begin
      chk("m0_stage", 128'(out_cfg[s*HALF +: HALF]), 128'(16'hFFFF));
    end
    run_req(32'hFFFF_FFFF, 1'b1, 0);
    chk("m1s_popcnt", 128'(out_popcnt), 128'(32));
    chk("m1s_stage4", 128'(out_cfg[4*HALF +: HALF]), 128'(16'h0000));
    run_req(32'h0000_0001, 1'b0, 0);
    chk("m1_stage2", 128'(out_cfg[2*HALF +: HALF]), 128'(16'hFFFE));
    run_req(32'h0000_FFFF, 1'b1, 10);
    chk("mffff_stage0", 128'(out_cfg[0 +: HALF]), 128'(16'hFF00));
    chk("mffff_stage3", 128'(out_cfg[3*HALF +: HALF]), 128'(16'hFF00));
    chk("mffff_stage4", 128'(out_cfg[4*HALF +: HALF]), 128'(16'h0000));

    run_req(32'h0000_FFFF, 1'b0, 0);
    flush_calc(32'h1234_5678);
    run_req(32'h0000_FFFF, 1'b1, 0);
    flush_accept(32'hA5A5_0F0F);
    run_req(32'h0000_FFFF, 1'b0, 2);
    rst_in_done(32'h8000_0001);
    run_req(32'h8000_0001, 1'b0, 0);

    m_prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      m_cur = (i % 3 == 2) ? m_prev : $urandom;
      run_req(m_cur, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      m_prev = m_cur;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
